// File: rtl/proc_pkg.sv
// Shared encodings for the proc_core multicycle load/store processor:
// opcodes, branch conditions, FSM states and instruction field positions.
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BR   = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] BR_AL = 3'b000;
  localparam logic [2:0] BR_Z  = 3'b001;
  localparam logic [2:0] BR_NZ = 3'b010;
  localparam logic [2:0] BR_N  = 3'b011;
  localparam logic [2:0] BR_C  = 3'b100;
  localparam logic [2:0] BR_V  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LOADWB, S_HALT
  } state_e;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 9;
  localparam int RS_HI = 8;
  localparam int RS_LO = 6;
  localparam int RT_HI = 5;
  localparam int RT_LO = 3;

endpackage

// File: rtl/reg_file_8x16.sv
// Eight general registers r0..r7: two combinational read ports, one
// synchronous write port, all cleared by synchronous reset.
module reg_file_8x16
  import proc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr_a,
  input  logic [2:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] r0, r1, r2, r3, r4, r5, r6, r7;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0;
      r4 <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
    end else if (we) begin
      case (waddr)
        3'd0: r0 <= wdata;
        3'd1: r1 <= wdata;
        3'd2: r2 <= wdata;
        3'd3: r3 <= wdata;
        3'd4: r4 <= wdata;
        3'd5: r5 <= wdata;
        3'd6: r6 <= wdata;
        default: r7 <= wdata;
      endcase
    end
  end

  function automatic logic [DW-1:0] rd_mux(input logic [2:0] a,
      input logic [DW-1:0] v0, v1, v2, v3, v4, v5, v6, v7);
    case (a)
      3'd0: return v0;
      3'd1: return v1;
      3'd2: return v2;
      3'd3: return v3;
      3'd4: return v4;
      3'd5: return v5;
      3'd6: return v6;
      default: return v7;
    endcase
  endfunction

  assign rdata_a = rd_mux(raddr_a, r0, r1, r2, r3, r4, r5, r6, r7);
  assign rdata_b = rd_mux(raddr_b, r0, r1, r2, r3, r4, r5, r6, r7);

endmodule

// File: rtl/proc_core.sv
// Multicycle 16-bit load/store core: FETCH/DECODE/EXEC(/LOADWB) over an
// external dual-port RAM with 1-cycle registered reads; inline ALU.
module proc_core
  import proc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 7,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_ram_dout,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          negative,
  output logic          overflow,
  output logic          carry,
  output logic [AW-1:0] pc,
  output logic          prog_ram_read_en,
  output logic          data_ram_read_en,
  output logic          write_ram_en,
  output logic [DW-1:0] data_ram_din,
  output logic [AW-1:0] data_ram_addr
);

  localparam int RW = $clog2(NREG);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, daddr_q, daddr_d;
  logic [DW-1:0] ir_q, ir_d, result_q, result_d, din_q, din_d;
  logic          z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;
  logic          pre_q, pre_d, dre_q, dre_d, wre_q, wre_d;

  logic [3:0]    op;
  logic          in_decode;
  logic [RW-1:0] raddr_a, raddr_b, rf_waddr;
  logic [DW-1:0] rdata_a, rdata_b, rf_wdata;
  logic          rf_we;

  logic [DW-1:0] alu_b, alu_res;
  logic [DW:0]   sum;
  logic          alu_c, alu_v, alu_wr, alu_flags, br_taken;

  assign op        = ir_q[OP_HI:OP_LO];
  assign in_decode = (state_q == S_DECODE);
  // During DECODE the ports look at the incoming word so LD/ST address and
  // store data can be registered in time for EXEC.
  assign raddr_a   = in_decode ? data_in[RS_HI:RS_LO] : ir_q[RS_HI:RS_LO];
  assign raddr_b   = in_decode ? data_in[RD_HI:RD_LO] : ir_q[RT_HI:RT_LO];
  assign rf_waddr  = ir_q[RD_HI:RD_LO];
  assign rf_wdata  = (state_q == S_LOADWB) ? data_ram_dout : alu_res;

  reg_file_8x16 #(.DW(DW)) reg_file_8x16_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );

  assign alu_b = (op == OP_ADDI) ? {{(DW-6){ir_q[5]}}, ir_q[5:0]} : rdata_b;

  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_c     = c_q;
    alu_v     = v_q;
    alu_wr    = 1'b0;
    alu_flags = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sum       = {1'b0, rdata_a} + {1'b0, alu_b};
        alu_res   = sum[DW-1:0];
        alu_c     = sum[DW];
        alu_v     = (rdata_a[DW-1] == alu_b[DW-1]) && (alu_res[DW-1] != rdata_a[DW-1]);
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_SUB: begin
        sum       = {1'b0, rdata_a} - {1'b0, rdata_b};
        alu_res   = sum[DW-1:0];
        alu_c     = ~sum[DW];  // no borrow means rs >= rt
        alu_v     = (rdata_a[DW-1] != rdata_b[DW-1]) && (alu_res[DW-1] != rdata_a[DW-1]);
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (op)
          OP_AND:  alu_res = rdata_a & rdata_b;
          OP_OR:   alu_res = rdata_a | rdata_b;
          OP_XOR:  alu_res = rdata_a ^ rdata_b;
          default: alu_res = ~rdata_a;
        endcase
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_SHL: begin
        alu_res   = {rdata_a[DW-2:0], 1'b0};
        alu_c     = rdata_a[DW-1];
        alu_v     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_SHR: begin
        alu_res   = {1'b0, rdata_a[DW-1:1]};
        alu_c     = rdata_a[0];
        alu_v     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_LDI: begin
        alu_res = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
        alu_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ir_q[RD_HI:RD_LO])
      BR_AL:   br_taken = 1'b1;
      BR_Z:    br_taken = z_q;
      BR_NZ:   br_taken = ~z_q;
      BR_N:    br_taken = n_q;
      BR_C:    br_taken = c_q;
      BR_V:    br_taken = v_q;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    c_d      = c_q;
    pre_d    = 1'b0;
    dre_d    = 1'b0;
    wre_d    = 1'b0;
    din_d    = din_q;
    daddr_d  = daddr_q;
    rf_we    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pre_d   = 1'b1;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = data_in;
        state_d = S_EXEC;
        if (data_in[OP_HI:OP_LO] == OP_LD || data_in[OP_HI:OP_LO] == OP_ST) begin
          daddr_d = rdata_a[AW-1:0];
          din_d   = rdata_b;
          dre_d   = (data_in[OP_HI:OP_LO] == OP_LD);
          wre_d   = (data_in[OP_HI:OP_LO] == OP_ST);
        end
      end
      S_EXEC: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else if (op == OP_LD) begin
          state_d = S_LOADWB;
        end else begin
          state_d = S_FETCH;
          pre_d   = 1'b1;
          pc_d    = (op == OP_BR && br_taken) ? ir_q[AW-1:0] : pc_q + AW'(1);
        end
        if (alu_wr) begin
          rf_we    = 1'b1;
          result_d = alu_res;
        end
        if (alu_flags) begin
          z_d = (alu_res == '0);
          n_d = alu_res[DW-1];
          c_d = alu_c;
          v_d = alu_v;
        end
      end
      S_LOADWB: begin
        rf_we    = 1'b1;
        result_d = data_ram_dout;
        pc_d     = pc_q + AW'(1);
        state_d  = S_FETCH;
        pre_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      pre_q    <= 1'b0;
      dre_q    <= 1'b0;
      wre_q    <= 1'b0;
      din_q    <= '0;
      daddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      c_q      <= c_d;
      pre_q    <= pre_d;
      dre_q    <= dre_d;
      wre_q    <= wre_d;
      din_q    <= din_d;
      daddr_q  <= daddr_d;
    end
  end

  assign result           = result_q;
  assign zero             = z_q;
  assign negative         = n_q;
  assign overflow         = v_q;
  assign carry            = c_q;
  assign pc               = pc_q;
  assign prog_ram_read_en = pre_q;
  assign data_ram_read_en = dre_q;
  // A reset landing on a store's EXEC cycle must not let the RAM commit it.
  assign write_ram_en     = wre_q & rst_n;
  assign data_ram_din     = din_q;
  assign data_ram_addr    = daddr_q;

endmodule

// File: tb/tb_proc_core.sv
// Scoreboard bench for proc_core: an ISA-level model predicts every register
// write and store (value and cycle); a negedge monitor checks them as they occur.
module tb_proc_core;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] data_in = '0, data_ram_dout = '0;
  logic [15:0] result, data_ram_din;
  logic        zero, negative, overflow, carry;
  logic [6:0]  pc, data_ram_addr;
  logic        prog_ram_read_en, data_ram_read_en, write_ram_en;

  logic [15:0] mem [128];

  always #5 clk = ~clk;

  proc_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .data_ram_dout(data_ram_dout), .result(result), .zero(zero),
    .negative(negative), .overflow(overflow), .carry(carry), .pc(pc),
    .prog_ram_read_en(prog_ram_read_en), .data_ram_read_en(data_ram_read_en),
    .write_ram_en(write_ram_en), .data_ram_din(data_ram_din),
    .data_ram_addr(data_ram_addr)
  );

  // Dual-port RAM: registered reads sampled before the write lands.
  always @(posedge clk) begin
    if (prog_ram_read_en) data_in <= mem[pc];
    if (data_ram_read_en) data_ram_dout <= mem[data_ram_addr];
    if (write_ram_en) mem[data_ram_addr] = data_ram_din;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { longint t; int a; logic [15:0] v; } ev_t;
  ev_t rq[$], sq[$];

  always @(negedge clk) begin
    ev_t e;
    if (dut.rf_we) begin
      if (rq.size() == 0) begin
        errors++; checks++;
        $display("FAIL rf_write: unexpected r%0d=0x%0h at %0t", dut.rf_waddr, dut.rf_wdata, $time);
      end else begin
        e = rq.pop_front();
        chk("rf_time", $time, e.t);
        chk("rf_addr", longint'(dut.rf_waddr), e.a);
        chk("rf_data", longint'(dut.rf_wdata), longint'(e.v));
      end
    end
    if (write_ram_en) begin
      if (sq.size() == 0) begin
        errors++; checks++;
        $display("FAIL store: unexpected [%0d]=0x%0h at %0t", data_ram_addr, data_ram_din, $time);
      end else begin
        e = sq.pop_front();
        chk("st_time", $time, e.t);
        chk("st_addr", longint'(data_ram_addr), e.a);
        chk("st_data", longint'(data_ram_din), longint'(e.v));
      end
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [15:0] mm [128];
  logic [15:0] mr [8];
  logic [15:0] mres;
  logic        mz, mn, mc, mv;
  int          mpc;
  longint      t0;

  function automatic longint ev_time(int cyc);
    return t0 + 10 + 10 * longint'(cyc);
  endfunction

  task automatic run_model(input int limit, output int cyc, output bit halted);
    logic [15:0] ins, val, bb;
    int op, rd, rs, a, b, u, sa, sb, s, npc, n;
    bit wr, flg, tk;
    ev_t e;
    cyc = 0; n = 0; halted = 0;
    while (!halted && n < limit) begin
      ins = mm[mpc];
      op = int'(ins[15:12]); rd = int'(ins[11:9]); rs = int'(ins[8:6]);
      a = int'(mr[rs]); b = int'(mr[ins[5:3]]);
      sa = int'($signed(mr[rs])); sb = int'($signed(mr[ins[5:3]]));
      wr = 0; flg = 0; val = '0; npc = (mpc + 1) % 128;
      case (op)
        1, 10: begin
          if (op == 10) begin
            sb = int'($signed(ins[5:0])); bb = 16'(sb); b = int'(bb);
          end
          u = a + b; val = 16'(u); s = sa + sb;
          mc = (u > 65535); mv = (s > 32767 || s < -32768); wr = 1; flg = 1;
        end
        2: begin
          u = a - b; val = 16'(u); s = sa - sb;
          mc = (a >= b); mv = (s > 32767 || s < -32768); wr = 1; flg = 1;
        end
        3, 4, 5, 6: begin
          case (op)
            3: val = mr[rs] & mr[ins[5:3]];
            4: val = mr[rs] | mr[ins[5:3]];
            5: val = mr[rs] ^ mr[ins[5:3]];
            default: val = 16'(65535 - a);
          endcase
          mc = 0; mv = 0; wr = 1; flg = 1;
        end
        7: begin val = 16'(a * 2); mc = (a >= 32768); mv = 0; wr = 1; flg = 1; end
        8: begin val = 16'(a / 2); mc = (a % 2 == 1); mv = 0; wr = 1; flg = 1; end
        9: begin val = 16'(int'($signed(ins[8:0]))); wr = 1; end
        11: begin val = mm[a % 128]; wr = 1; end
        12: begin
          mm[a % 128] = mr[rd];
          e.t = ev_time(cyc + 2); e.a = a % 128; e.v = mr[rd]; sq.push_back(e);
        end
        13: begin
          case (rd)
            0: tk = 1; 1: tk = mz; 2: tk = !mz; 3: tk = mn; 4: tk = mc; 5: tk = mv;
            default: tk = 0;
          endcase
          if (tk) npc = int'(ins[6:0]);
        end
        15: begin halted = 1; npc = mpc; end
        default: ;
      endcase
      if (wr) begin
        mr[rd] = val; mres = val;
        e.t = ev_time(cyc + (op == 11 ? 3 : 2)); e.a = rd; e.v = val; rq.push_back(e);
      end
      if (flg) begin mz = (val == 0); mn = val[15]; end
      cyc += (op == 11) ? 4 : 3;
      mpc = npc; n++;
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [15:0] rrr(int op, int rd, int rs, int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction
  function automatic logic [15:0] ldi(int rd, int imm);
    return {4'h9, 3'(rd), 9'(imm)};
  endfunction
  function automatic logic [15:0] addi(int rd, int rs, int imm);
    return {4'hA, 3'(rd), 3'(rs), 6'(imm)};
  endfunction
  function automatic logic [15:0] br(int cond, int tgt);
    return {4'hD, 3'(cond), 2'b00, 7'(tgt)};
  endfunction
  function automatic logic [15:0] lds(int op, int rd, int rs);
    return {4'(op), 3'(rd), 3'(rs), 6'd0};
  endfunction
  localparam logic [15:0] HALT = 16'hF000;

  function automatic logic [15:0] dut_reg(int i);
    case (i)
      0: return dut.reg_file_8x16_1.r0;
      1: return dut.reg_file_8x16_1.r1;
      2: return dut.reg_file_8x16_1.r2;
      3: return dut.reg_file_8x16_1.r3;
      4: return dut.reg_file_8x16_1.r4;
      5: return dut.reg_file_8x16_1.r5;
      6: return dut.reg_file_8x16_1.r6;
      default: return dut.reg_file_8x16_1.r7;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  // Starts the core on the current memory image; the model predicts up to
  // `limit` instructions. Returns with start dropped, 1 cycle into FETCH0.
  task automatic launch(input int limit, output int cyc, output bit halted);
    @(negedge clk);
    t0 = $time;
    mm = mem;
    for (int i = 0; i < 8; i++) mr[i] = '0;
    mz = 0; mn = 0; mc = 0; mv = 0; mpc = 0; mres = '0;
    run_model(limit, cyc, halted);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic final_check(input string tag);
    int bad;
    chk({tag, "_rq_left"}, rq.size(), 0);
    chk({tag, "_sq_left"}, sq.size(), 0);
    rq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), dut_reg(i), mr[i]);
    chk({tag, "_Z"}, zero, mz);
    chk({tag, "_N"}, negative, mn);
    chk({tag, "_C"}, carry, mc);
    chk({tag, "_V"}, overflow, mv);
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_result"}, result, mres);
    chk({tag, "_halt_fetch_en"}, prog_ram_read_en, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== mm[i]) bad++;
    chk({tag, "_mem_words_differing"}, bad, 0);
  endtask

  task automatic run_full(input string tag);
    int cyc; bit halted;
    launch(5000, cyc, halted);
    if (!halted) begin
      errors++; checks++;
      $display("FAIL %s_model: program did not halt", tag);
    end
    repeat (cyc + 4) @(negedge clk);
    final_check(tag);
  endtask

  task automatic gen_rand();
    int ops[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
    int i, len, k;
    clear_mem();
    for (int j = 64; j < 128; j++) mem[j] = 16'($urandom);
    for (int j = 0; j < 7; j++) mem[j] = ldi(j, $urandom_range(0, 511));
    i = 7; len = $urandom_range(15, 35);
    while (i < len) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin
        if ($urandom_range(0, 3) == 0)
          mem[i] = addi($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
        else
          mem[i] = rrr(ops[$urandom_range(0, 8)], $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7));
        i++;
      end else if (k == 6) begin
        mem[i] = ldi($urandom_range(0, 7), $urandom_range(0, 511)); i++;
      end else if (k == 7) begin
        mem[i] = ldi(7, 64 + $urandom_range(0, 63));
        mem[i+1] = lds($urandom_range(0, 1) ? 11 : 12, $urandom_range(0, 7), 7);
        i += 2;
      end else if (k == 8) begin
        mem[i] = br($urandom_range(0, 7), i + 1 + $urandom_range(0, 3)); i++;
      end else begin
        mem[i] = $urandom_range(0, 1) ? 16'h0000 : 16'hE000; i++;
      end
    end
    for (int j = i; j < 64; j++) mem[j] = HALT;
  endtask

  initial begin
    int cyc; bit halted;

    // reset state
    clear_mem();
    do_reset();
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, negative, overflow, carry}, 0);
    chk("rst_enables", {prog_ram_read_en, data_ram_read_en, write_ram_en}, 0);
    chk("rst_din", data_ram_din, 0);
    chk("rst_addr", data_ram_addr, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), dut_reg(i), 0);

    // basic add
    clear_mem();
    mem[0] = ldi(1, 5); mem[1] = ldi(2, 3); mem[2] = rrr(1, 3, 1, 2); mem[3] = HALT;
    run_full("add");
    chk("add_r3_is_8", dut_reg(3), 16'd8);
    chk("add_pc_is_3", pc, 3);

    // overflow
    do_reset(); clear_mem();
    mem[0] = ldi(1, 255);
    for (int i = 1; i <= 7; i++) mem[i] = rrr(7, 1, 1, 0);
    mem[8] = addi(1, 1, 31); mem[9] = addi(1, 1, 31);
    mem[10] = addi(1, 1, 31); mem[11] = addi(1, 1, 31); mem[12] = addi(1, 1, 3);
    mem[13] = ldi(2, 1); mem[14] = rrr(1, 3, 1, 2); mem[15] = HALT;
    run_full("ovf");
    chk("ovf_r3", dut_reg(3), 16'h8000);
    chk("ovf_VNC", {overflow, negative, carry}, 3'b110);

    // subtract + branches
    do_reset(); clear_mem();
    mem[0] = ldi(1, 3); mem[1] = ldi(2, 3); mem[2] = rrr(2, 3, 1, 2); mem[3] = br(1, 10);
    for (int i = 4; i < 10; i++) mem[i] = HALT;
    mem[10] = ldi(1, 2); mem[11] = rrr(2, 4, 1, 2); mem[12] = br(1, 20); mem[13] = HALT;
    mem[20] = HALT;
    run_full("sub");
    chk("sub_pc", pc, 13);
    chk("sub_r4", dut_reg(4), 16'hFFFF);

    // store / load
    do_reset(); clear_mem();
    mem[0] = ldi(1, 145);
    for (int i = 1; i <= 5; i++) mem[i] = rrr(7, 1, 1, 0);
    mem[6] = addi(1, 1, 20); mem[7] = ldi(2, 100);
    mem[8] = lds(12, 1, 2); mem[9] = lds(11, 4, 2); mem[10] = HALT;
    run_full("mem");
    chk("mem_r4", dut_reg(4), 16'h1234);

    // pc wrap 127 -> 0
    do_reset(); clear_mem();
    mem[0] = addi(5, 5, 1); mem[1] = addi(6, 5, -2); mem[2] = br(1, 4);
    mem[3] = br(0, 127); mem[4] = HALT;
    run_full("wrap");
    chk("wrap_pc", pc, 4);
    chk("wrap_r5", dut_reg(5), 2);

    // reset during EXEC of a store
    do_reset(); clear_mem();
    mem[0] = ldi(1, 16'h0AB); mem[1] = ldi(2, 100); mem[2] = lds(12, 1, 2); mem[3] = HALT;
    mem[100] = 16'h5555;
    launch(3, cyc, halted);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem100", mem[100], 16'h5555);
    chk("abort_rq_left", rq.size(), 0);
    chk("abort_sq_left", sq.size(), 0);
    rq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) chk($sformatf("abort_r%0d", i), dut_reg(i), 0);
    chk("abort_flags", {zero, negative, overflow, carry}, 0);
    repeat (5) @(negedge clk);
    chk("abort_idle_pc", pc, 0);
    chk("abort_idle_fetch", prog_ram_read_en, 0);
    run_full("rerun");
    chk("rerun_mem100", mem[100], 16'h00AB);

    // random programs
    for (int p = 0; p < 8; p++) begin
      do_reset();
      gen_rand();
      run_full($sformatf("rand%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
